// File: rtl/load_store_unit.sv
// load_store_unit: turns a level load/store request into one word-aligned bus transaction with byte strobes.
// Define MISALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        bus_err,
    output logic        misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;
    state_t state, state_next;
    logic start, is_b, is_h, mis_trap, timeout;
    logic [2:0] f3;
    logic [1:0] lo;
    logic [7:0] cnt;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext;
    assign start = mem_read_enable | mem_write_enable;
    assign is_b = funct3[1:0] == 2'b00;
    assign is_h = funct3[1:0] == 2'b01;
`ifdef MISALIGN_CHECK_EN
    assign mis_trap = is_h ? addr[0] : (!is_b && addr[1:0] != 2'b00);
`else
    assign mis_trap = 1'b0;
`endif
    assign timeout = cnt == 8'(TIMEOUT_CYC - 1);
    assign busy = (state == IDLE && start) || state == REQ;
    assign done = state == RESP;
    assign bus_req = state == REQ;
    // Lane extraction uses the low address bits captured at start, not the live ALU result
    assign rbyte = bus_rdata[{lo, 3'b000} +: 8];
    assign rhalf = bus_rdata[{lo[1], 4'b0000} +: 16];
    always_comb begin
        ext = bus_rdata;
        ext = f3 == 3'b000 ? {{24{rbyte[7]}}, rbyte} :
              f3 == 3'b100 ? {24'b0, rbyte} :
              f3 == 3'b001 ? {{16{rhalf[15]}}, rhalf} :
              f3 == 3'b101 ? {16'b0, rhalf} : bus_rdata;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = !start ? IDLE : mis_trap ? RESP : REQ;
            REQ: state_next = (bus_ack || timeout) ? RESP : REQ;
            RESP: state_next = start ? HOLD : IDLE;
            HOLD: state_next = start ? HOLD : IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt <= '0;
            f3 <= '0;
            lo <= '0;
            load_data <= '0;
            bus_err <= 1'b0;
            misaligned <= 1'b0;
            bus_we <= 1'b0;
            bus_addr <= '0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                f3 <= funct3;
                lo <= addr[1:0];
                cnt <= '0;
                bus_err <= 1'b0;
                misaligned <= mis_trap;
                bus_we <= mem_write_enable;
                bus_addr <= {addr[31:2], 2'b00};
                bus_wdata <= is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
                bus_wstrb <= !mem_write_enable ? 4'b0000 :
                             is_b ? 4'b0001 << addr[1:0] :
                             is_h ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
                if (mis_trap && !mem_write_enable)
                    load_data <= '0;
            end
            if (state == REQ) begin
                cnt <= cnt + 8'd1;
                if (bus_ack) begin
                    if (!bus_we)
                        load_data <= ext;
                end else if (timeout) begin
                    bus_err <= 1'b1;
                    if (!bus_we)
                        load_data <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and randomized checks of load_store_unit against a spec-level model.
module tb_load_store_unit;
    localparam int TO = 4;
`ifdef MISALIGN_CHECK_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef struct {
        int we, re, f3;
        logic [31:0] addr, sdata, rdata;
        int ack_at, hold, strb;
        logic [31:0] wdata, load;
        int err, mis, reqs, done_cyc;
    } vec_t;

    logic clk = 0, resetn = 0, mem_read_enable = 0, mem_write_enable = 0, bus_ack = 0;
    logic [2:0] funct3 = 0;
    logic [31:0] addr = 0, store_data = 0, bus_rdata = 0;
    logic busy, done, bus_err, misaligned, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0] bus_wstrb;
    int checks = 0, errors = 0;
    logic [31:0] ref_load = 0;
    vec_t tbl[11];
    int fsel[5] = '{0, 1, 2, 4, 5};

    load_store_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .resetn(resetn),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .load_data(load_data),
        .bus_err(bus_err), .misaligned(misaligned),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input int f, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) & 32'hFF;
        h = (r >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (f)
            0: return b >= 32'd128 ? b - 32'd256 : b;
            4: return b;
            1: return h >= 32'd32768 ? h - 32'd65536 : h;
            5: return h;
            default: return r;
        endcase
    endfunction

    function automatic int m_mis(input int f, input logic [31:0] a);
        if (f == 1 || f == 5) return int'(a % 2 != 0);
        if (f == 0 || f == 4) return 0;
        return int'(a % 4 != 0);
    endfunction

    function automatic vec_t make_vec(input int we, input int re, input int f, input logic [31:0] a,
                                      input logic [31:0] d, input logic [31:0] r, input int ack_at, input int hold);
        vec_t v;
        int trap, acked;
        trap = (TRAP && m_mis(f, a) != 0) ? 1 : 0;
        acked = (ack_at >= 1 && ack_at <= TO) ? 1 : 0;
        v.we = we; v.re = re; v.f3 = f; v.addr = a; v.sdata = d; v.rdata = r;
        v.ack_at = ack_at; v.hold = hold;
        v.strb = we == 0 ? 0 : f == 0 ? 1 << (a % 4) : f == 1 ? 3 << (a & 2) : 15;
        v.wdata = f == 0 ? (d & 32'hFF) * 32'h01010101 : f == 1 ? (d & 32'hFFFF) * 32'h00010001 : d;
        v.mis = trap;
        v.err = (trap == 0 && acked == 0) ? 1 : 0;
        v.reqs = trap != 0 ? 0 : acked != 0 ? ack_at : TO;
        v.done_cyc = v.reqs + 1;
        v.load = (trap != 0 || acked == 0) ? 32'h0 : m_load(f, a, r);
        return v;
    endfunction

    task automatic run(input vec_t v);
        int cyc, reqs, busy_bad, extra;
        bit got;
        cyc = 0; reqs = 0; busy_bad = 0; extra = 0; got = 0;
        @(negedge clk);
        mem_write_enable = v.we != 0;
        mem_read_enable = v.re != 0;
        funct3 = 3'(v.f3);
        addr = v.addr;
        store_data = v.sdata;
        bus_ack = 0;
        #1 if (!busy) busy_bad++;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            bus_ack = 0;
            #1;
            if (done) begin
                got = 1;
                chk("done_cycle", cyc, v.done_cyc);
                chk("busy_at_done", 32'(busy), 0);
                chk("bus_err", 32'(bus_err), v.err);
                chk("misaligned", 32'(misaligned), v.mis);
                if (v.re != 0 && v.we == 0) ref_load = v.load;
                chk("load_data", load_data, ref_load);
            end else if (!busy) busy_bad++;
            if (bus_req) begin
                reqs++;
                if (reqs == 1) begin
                    chk("bus_addr", bus_addr, v.addr & 32'hFFFFFFFC);
                    chk("bus_we", 32'(bus_we), v.we);
                    chk("bus_wstrb", 32'(bus_wstrb), v.strb);
                    if (v.we != 0) chk("bus_wdata", bus_wdata, v.wdata);
                end
                bus_ack = reqs == v.ack_at;
                bus_rdata = bus_ack ? v.rdata : $urandom;
            end
        end
        chk("done_seen", 32'(got), 1);
        chk("req_cycles", reqs, v.reqs);
        chk("busy_profile", busy_bad, 0);
        repeat (v.hold) begin
            @(negedge clk);
            #1 if (busy || done || bus_req) extra++;
        end
        mem_read_enable = 0;
        mem_write_enable = 0;
        @(negedge clk);
        #1;
        chk("held_level", extra, 0);
        chk("idle", 32'({busy, done, bus_req}), 0);
    endtask

    initial begin
        tbl[0] = '{1, 0, 2, 32'h104, 32'hDEADBEEF, 32'h0, 2, 0, 15, 32'hDEADBEEF, 32'h0, 0, 0, 2, 3};
        tbl[1] = '{0, 1, 0, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 0, 32'h0, 32'hFFFFFF80, 0, 0, 1, 2};
        tbl[2] = '{0, 1, 4, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 0, 32'h0, 32'h00000080, 0, 0, 1, 2};
        tbl[3] = '{0, 1, 1, 32'h102, 32'h0, 32'h80011234, 1, 0, 0, 32'h0, 32'hFFFF8001, 0, 0, 1, 2};
        tbl[4] = '{1, 0, 1, 32'h102, 32'h0000ABCD, 32'h0, 1, 0, 12, 32'hABCDABCD, 32'h0, 0, 0, 1, 2};
        tbl[5] = '{1, 0, 0, 32'h101, 32'h12345678, 32'h0, 3, 0, 2, 32'h78787878, 32'h0, 0, 0, 3, 4};
        tbl[6] = '{0, 1, 5, 32'h100, 32'h0, 32'h1234F00D, 1, 0, 0, 32'h0, 32'h0000F00D, 0, 0, 1, 2};
        tbl[7] = '{0, 1, 2, 32'h200, 32'h0, 32'hCAFEF00D, 3, 5, 0, 32'h0, 32'hCAFEF00D, 0, 0, 3, 4};
        tbl[8] = '{0, 1, 2, 32'h300, 32'h0, 32'h11111111, 0, 0, 0, 32'h0, 32'h0, 1, 0, 4, 5};
        tbl[9] = '{1, 1, 2, 32'h10, 32'h01020304, 32'h0, 1, 2, 15, 32'h01020304, 32'h0, 0, 0, 1, 2};
`ifdef MISALIGN_CHECK_EN
        tbl[10] = '{0, 1, 2, 32'h101, 32'h0, 32'h55AA55AA, 1, 0, 0, 32'h0, 32'h0, 0, 1, 0, 1};
`else
        tbl[10] = '{0, 1, 2, 32'h101, 32'h0, 32'h55AA55AA, 1, 0, 0, 32'h0, 32'h55AA55AA, 0, 0, 1, 2};
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", 32'({busy, done, bus_err, misaligned, bus_req, bus_we}), 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 0);
        resetn = 1;
        for (int i = 0; i < 11; i++) run(tbl[i]);
        for (int i = 0; i < 150; i++) begin
            int we, re, f;
            we = int'($urandom_range(0, 1));
            re = (we == 0 || $urandom_range(0, 3) == 0) ? 1 : 0;
            f = we != 0 ? int'($urandom_range(0, 2)) : fsel[$urandom_range(0, 4)];
            run(make_vec(we, re, f, $urandom, $urandom, $urandom,
                         int'($urandom_range(1, 5)), int'($urandom_range(0, 2))));
        end
        @(negedge clk);
        mem_read_enable = 1;
        funct3 = 3'b010;
        addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        #1 chk("req_before_reset", 32'(bus_req), 1);
        #2 resetn = 0;
        mem_read_enable = 0;
        #1;
        chk("req_async_reset", 32'(bus_req), 0);
        chk("busy_in_reset", 32'(busy), 0);
        chk("load_data_in_reset", load_data, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
